// File: rtl/rv_decode_stage.sv
// RV32I decode stage: field extraction, immediate generation, busy scoreboard and RAW stall.
// Optional DEC_WB_BYPASS_EN: a same-cycle writeback retire masks its busy bit in the hazard check.
module rv_decode_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_imm,
  output logic            ex_rd_wen,
  output logic            ex_illegal,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic            wb_rd_wen
);

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_IMM    = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_FENCE  = 7'b0001111,
    OPC_SYSTEM = 7'b1110011
  } opcode_e;

  logic [NREG-1:0] busy, busy_n, busy_chk;
  logic [XLEN-1:0] imm_d;
  logic [4:0]      rs1_d, rs2_d, rd_d;
  logic            legal, rs1_used, rs2_used, wen_op, rd_wen_d;
  logic            haz1, haz2, hazard, accept, issue;

  assign rs1_d = if_instr[19:15];
  assign rs2_d = if_instr[24:20];
  assign rd_d  = if_instr[11:7];

  always_comb begin
    imm_d    = '0;
    legal    = 1'b1;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    wen_op   = 1'b0;
    case (if_instr[6:0])
      OPC_LUI, OPC_AUIPC: begin
        imm_d  = {if_instr[31:12], 12'b0};
        wen_op = 1'b1;
      end
      OPC_JAL: begin
        imm_d  = {{12{if_instr[31]}}, if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};
        wen_op = 1'b1;
      end
      OPC_JALR, OPC_LOAD, OPC_IMM: begin
        imm_d    = {{20{if_instr[31]}}, if_instr[31:20]};
        rs1_used = 1'b1;
        wen_op   = 1'b1;
      end
      OPC_BRANCH: begin
        imm_d    = {{20{if_instr[31]}}, if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OPC_STORE: begin
        imm_d    = {{21{if_instr[31]}}, if_instr[30:25], if_instr[11:7]};
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OPC_OP: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        wen_op   = 1'b1;
      end
      OPC_SYSTEM: imm_d = {{20{if_instr[31]}}, if_instr[31:20]};
      OPC_FENCE:  imm_d = '0;
      default:    legal = 1'b0;
    endcase
  end

  assign rd_wen_d = wen_op & (rd_d != 5'd0);

  always_comb begin
    busy_chk = busy;
`ifdef DEC_WB_BYPASS_EN
    if (wb_valid && wb_rd_wen) busy_chk[wb_rd] = 1'b0;
`endif
  end

  // The held bundle has not issued yet, so its rd is not in busy: compare directly.
  assign haz1 = rs1_used && (rs1_d != 5'd0) &&
                (busy_chk[rs1_d] || (ex_valid && ex_rd_wen && ex_rd == rs1_d));
  assign haz2 = rs2_used && (rs2_d != 5'd0) &&
                (busy_chk[rs2_d] || (ex_valid && ex_rd_wen && ex_rd == rs2_d));
  assign hazard = legal & (haz1 | haz2);

  assign if_ready = (!ex_valid || ex_ready) && !hazard && !flush;
  assign accept   = if_valid & if_ready;
  assign issue    = ex_valid & ex_ready & ~flush;

  // Clear applied before set so a newer producer on the same index stays pending.
  always_comb begin
    busy_n = busy;
    if (wb_valid && wb_rd_wen) busy_n[wb_rd] = 1'b0;
    if (issue && ex_rd_wen)    busy_n[ex_rd] = 1'b1;
    busy_n[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy        <= '0;
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_opcode   <= '0;
      ex_funct3   <= '0;
      ex_funct7b5 <= 1'b0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_imm      <= '0;
      ex_rd_wen   <= 1'b0;
      ex_illegal  <= 1'b0;
    end else begin
      busy <= busy_n;
      if (flush) begin
        ex_valid <= 1'b0;
      end else if (accept) begin
        ex_valid    <= 1'b1;
        ex_pc       <= if_pc;
        ex_opcode   <= if_instr[6:0];
        ex_funct3   <= if_instr[14:12];
        ex_funct7b5 <= if_instr[30];
        ex_rs1      <= rs1_d;
        ex_rs2      <= rs2_d;
        ex_rd       <= rd_d;
        ex_imm      <= legal ? imm_d : '0;
        ex_rd_wen   <= legal & rd_wen_d;
        ex_illegal  <= ~legal;
      end else if (ex_ready) begin
        ex_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Decode stage directly upstream of the register file in the RV32I core.
- Accepts fetched instructions over a valid/ready handshake and extracts rs1/rs2/rd, which drive the register file read/write indices.
- Generates the sign-extended immediate and holds the decoded bundle in a single output register toward execute.
- Keeps a 32-entry busy scoreboard and stalls read-after-write hazards until writeback retires the producing instruction.

Parameters:
- XLEN, 32, datapath/PC/immediate width; only 32 is supported.
- NREG, 32, number of architectural registers tracked by the scoreboard; x0 is never busy.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- if_valid  input  1  fetch presents an instruction.
- if_ready  output  1  decode accepts this cycle.
- if_instr  input  32  instruction word.
- if_pc  input  32  instruction address.
- flush  input  1  kill the instruction held in the output register.
- ex_valid  output  1  decoded bundle valid.
- ex_ready  input  1  execute accepts the bundle.
- ex_pc  output  32  PC of the bundle.
- ex_opcode  output  7  instr[6:0].
- ex_funct3  output  3  instr[14:12].
- ex_funct7b5  output  1  instr[30].
- ex_rs1, ex_rs2, ex_rd  output  5 each  register indices (feed the register file).
- ex_imm  output  32  sign-extended immediate.
- ex_rd_wen  output  1  bundle writes rd (never set for rd=0).
- ex_illegal  output  1  unsupported encoding.
- wb_valid  input  1  writeback retires one instruction.
- wb_rd  input  5  rd of the retiring instruction.
- wb_rd_wen  input  1  retiring instruction had rd_wen set.

Behaviour:
- Reset (rst=0, asynchronous): ex_valid=0; every ex_* output=0; busy vector=0. Reset mid-operation discards the held bundle and all scoreboard state.
- Decode is combinational from if_instr. Registered outputs: 1-cycle latency from the accept edge to ex_valid.
- Supported opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011, FENCE 0001111, SYSTEM 1110011.
- Illegal encodings (any other opcode, or instr[1:0]!=2'b11): ex_illegal=1, ex_rd_wen=0, ex_imm=0, no hazard check.
- Immediate formats:
  - I: JALR, LOAD, OP-IMM, SYSTEM.
  - S: STORE.
  - B: BRANCH, bit0=0.
  - U: LUI, AUIPC, low 12 bits = 0.
  - J: JAL, bit0=0.
  - All formats sign-extend from instr[31]. FENCE: imm=0.
- Operand usage:
  - rs1 used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - rs2 used by BRANCH, STORE, OP.
  - rd_wen for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, and only when rd!=0.
- hazard = (rs1 used, rs1!=0, busy[rs1] or matches a held ex_rd with ex_valid&ex_rd_wen) OR the same condition for rs2.
- if_ready = (!ex_valid | ex_ready) & !hazard & !flush.
- Accept (if_valid & if_ready): load the output register, ex_valid=1. A bundle held with ex_ready=0 keeps all outputs stable.
- Issue (ex_valid & ex_ready): if ex_rd_wen, set busy[ex_rd] on that edge. ex_valid drops unless a new accept occurs in the same cycle.
- Retire (wb_valid & wb_rd_wen): clear busy[wb_rd].
- Set and clear of the same index on the same edge: set wins, because the newer producer remains pending.
- Every issued instruction produces exactly one wb_valid pulse, including instructions killed downstream; the scoreboard relies on this.
- Flush: ex_valid=0 on the next edge; the held bundle never issues and sets no busy bit; no accept that cycle. Flush takes priority over ex_ready in the same cycle.
- Any number of busy bits may be set concurrently; no overflow condition exists.

Optional Feature:
- Macro: DEC_WB_BYPASS_EN.
- Defined: a retire of index r in the current cycle masks busy[r] in the hazard check, so a dependent instruction is accepted in the same cycle as its producer's writeback. The register file write-first path must cover this.
- Undefined: the hazard check uses the registered busy vector only. The dependent instruction is accepted one cycle after the wb_valid edge.

Test Plan:
- Reset release, then `addi x5,x0,-1` (0xFFF00293) with ex_ready=1 → next cycle ex_valid=1, ex_rd=5, ex_imm=0xFFFFFFFF, ex_rd_wen=1. The cycle after, busy[5]=1.
- Back-to-back `add x6,x5,x5` after the addi → if_ready=0 until wb_valid with wb_rd=5, wb_rd_wen=1.
  - Accepted one cycle later without DEC_WB_BYPASS_EN.
  - Accepted in the same cycle with it.
- `addi x0,x0,1` then `add x1,x0,x0` → ex_rd_wen=0 for the first, no stall for the second, busy stays 0.
- ex_ready held 0 for 3 cycles with `jal x1,-4` (0xFFDFF0EF) held → outputs stable, ex_imm=0xFFFFFFFC, if_ready=0. flush=1 then gives ex_valid=0, busy[1]=0.
- Instruction 0x00000000 → ex_illegal=1, ex_rd_wen=0, no stall. Also drive an issue setting busy[7] on the same edge as a retire of rd=7 → busy[7]=1 afterwards.
- rst=0 asserted asynchronously mid-stall with busy[5]=1 → ex_valid drops immediately (no clock edge); busy vector all 0.
